// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the synchronous RAM bank.
package sync_ram_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        READY = 2'd1,
        CLEAR = 2'd2
    } ram_state_e;

    localparam int MAX_RD_LAT = 4;
    // Widest word be_merge handles; callers zero-extend and truncate.
    localparam int MAX_DWIDTH = 512;

    // Replace each byte of old_word whose enable bit is set with the same byte of new_word.
    function automatic logic [MAX_DWIDTH-1:0] be_merge(
        input logic [MAX_DWIDTH-1:0]   old_word,
        input logic [MAX_DWIDTH-1:0]   new_word,
        input logic [MAX_DWIDTH/8-1:0] be
    );
        logic [MAX_DWIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_DWIDTH/8; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sync_ram_rsp_pipe.sv
// Fixed-latency response pipeline: {valid, rdata, err} delayed by RD_LAT edges.
module sync_ram_rsp_pipe #(
    parameter int DWIDTH = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_rdata,
    input  logic              in_err,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_rdata,
    output logic              out_err
);

    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][DWIDTH-1:0] data_pipe;
    logic [RD_LAT:1]             err_pipe;

    // Valid bits are reset so a reset flushes every response in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Payload shifts alongside; no reset needed because outputs are gated by valid.
    always_ff @(posedge clk) begin
        data_pipe[1] <= in_rdata;
        err_pipe[1]  <= in_err;
        for (int i = 2; i <= RD_LAT; i++) begin
            data_pipe[i] <= data_pipe[i-1];
            err_pipe[i]  <= err_pipe[i-1];
        end
    end

    assign out_valid = vld_pipe[RD_LAT];
    assign out_rdata = vld_pipe[RD_LAT] ? data_pipe[RD_LAT] : '0;
    assign out_err   = vld_pipe[RD_LAT] & err_pipe[RD_LAT];

endmodule

// File: rtl/sync_ram_bank.sv
// Single-port RAM bank with byte enables, valid/ready requests, fixed-latency
// in-order responses, self zero-fill after reset or on clear, range checking.
module sync_ram_bank
    import sync_ram_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 2**AWIDTH,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [AWIDTH-1:0]   req_addr,
    input  logic [DWIDTH-1:0]   req_wdata,
    input  logic [DWIDTH/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DWIDTH-1:0]   rsp_rdata,
    output logic                rsp_err,
    input  logic                clear,
    output logic                init_busy
);

    localparam int BW = DWIDTH/8;
    localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH-1);

    if (DWIDTH % 8 != 0 || DWIDTH > MAX_DWIDTH) begin : g_bad_dwidth
        $error("sync_ram_bank: DWIDTH must be a multiple of 8 and at most MAX_DWIDTH");
    end
    if (DEPTH < 1 || DEPTH > 2**AWIDTH) begin : g_bad_depth
        $error("sync_ram_bank: DEPTH must be in 1..2**AWIDTH");
    end
    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
        $error("sync_ram_bank: RD_LAT must be in 1..MAX_RD_LAT");
    end

    ram_state_e        state, state_nxt;
    logic [AWIDTH-1:0] fill_cnt, fill_nxt;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rd_word, wr_word, rsp_in_rdata;
    logic              accept, in_range, fill_last;

    assign req_ready = (state == READY);
    assign init_busy = (state != READY);
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_W);
    assign fill_last = (fill_cnt == LAST_ADDR);

    // Old contents feed both the read response and the byte merge of a write.
    assign rd_word = mem[req_addr];
    assign wr_word = DWIDTH'(be_merge(MAX_DWIDTH'(rd_word), MAX_DWIDTH'(req_wdata),
                                      (MAX_DWIDTH/8)'(req_be)));

    // State and fill counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            fill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_nxt;
        end
    end

    // Next state: fill states walk every address once, READY waits for clear.
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_cnt;
        unique case (state)
            INIT, CLEAR: begin
                if (fill_last) begin
                    state_nxt = READY;
                    fill_nxt  = '0;
                end else begin
                    fill_nxt = fill_cnt + 1'b1;
                end
            end
            READY: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    fill_nxt  = '0;
                end
            end
            default: begin
                state_nxt = INIT;
                fill_nxt  = '0;
            end
        endcase
    end

    // Storage: zero-fill while busy, byte-merged request writes while ready.
    always_ff @(posedge clk) begin
        if (state != READY) begin
            mem[fill_cnt] <= '0;
        end else if (accept && req_we && in_range) begin
            mem[req_addr] <= wr_word;
        end
    end

    // Writes and out-of-range reads respond with zero data.
    assign rsp_in_rdata = (accept && !req_we && in_range) ? rd_word : '0;

    sync_ram_rsp_pipe #(
        .DWIDTH (DWIDTH),
        .RD_LAT (RD_LAT)
    ) u_rsp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_rdata  (rsp_in_rdata),
        .in_err    (accept && !in_range),
        .out_valid (rsp_valid),
        .out_rdata (rsp_rdata),
        .out_err   (rsp_err)
    );

    logic unused_bw;
    assign unused_bw = (BW == 0);

endmodule

// File: tb/tb_sync_ram_bank.sv
// Randomized and directed bench for sync_ram_bank against a word-array model.
module tb_sync_ram_bank;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 200;
    localparam int RL    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [1:0]    req_be = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          clear = 1'b0;
    logic          init_busy;

    sync_ram_bank #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .RD_LAT(RL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .clear     (clear),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mdl [0:255];
    int          cyc = 0;
    int          busy_left = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 256; i++) mdl[i] = 16'h0000;
    endtask

    task automatic chk_reset_vals();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_init_busy", 32'(init_busy), 32'd1);
    endtask

    // Hold reset for n cycles checking outputs, then release; model restarts the fill.
    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        q.delete();
        repeat (n) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            chk_reset_vals();
        end
        rst_n = 1'b1;
        busy_left = DEPTH;
        model_zero();
    endtask

    // One clock: predict acceptance from the model, advance, then check outputs.
    task automatic tick();
        exp_t e;
        bit   rdy;
        rdy = (busy_left == 0);
        chk("req_ready", 32'(req_ready), 32'(rdy));
        chk("init_busy", 32'(init_busy), 32'(!rdy));
        if (req_valid && rdy) begin
            e.due  = cyc + RL;
            e.err  = (int'(req_addr) >= DEPTH);
            e.data = 16'h0000;
            if (!e.err && !req_we) e.data = mdl[req_addr];
            if (!e.err && req_we)
                for (int b = 0; b < 2; b++)
                    if (req_be[b]) mdl[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            q.push_back(e);
        end
        if (busy_left > 0) busy_left--;
        else if (clear) begin
            busy_left = DEPTH;
            model_zero();
        end
        @(posedge clk); cyc++;
        @(negedge clk);
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_rdata", 32'(rsp_rdata), 32'(q[0].data));
            chk("rsp_err",   32'(rsp_err),   32'(q[0].err));
            void'(q.pop_front());
        end else begin
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_rsp_rdata", 32'(rsp_rdata), 32'd0);
            chk("idle_rsp_err",   32'(rsp_err),   32'd0);
        end
    endtask

    task automatic req(input logic we, input int addr, input logic [15:0] d, input logic [1:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = AW'(addr);
        req_wdata = d;
        req_be    = be;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        model_zero();
        #2;
        hold_reset(3);

        // Fill after reset, then reads of the corners.
        idle(DEPTH);
        req(1'b0, 0,   16'h0, 2'b00);
        req(1'b0, 99,  16'h0, 2'b00);
        req(1'b0, 199, 16'h0, 2'b00);
        idle(3);

        // Byte-enable merge.
        req(1'b1, 5, 16'hABCD, 2'b11);
        req(1'b1, 5, 16'h1234, 2'b01);
        req(1'b0, 5, 16'h0, 2'b00);
        idle(3);

        // Write then read next cycle, then ten streamed reads.
        req(1'b1, 7, 16'h5555, 2'b11);
        req(1'b0, 7, 16'h0, 2'b00);
        for (int i = 0; i < 10; i++) req(1'b0, 7 + i, 16'h0, 2'b00);
        req(1'b1, 9, 16'h00FF, 2'b00);
        req(1'b0, 9, 16'h0, 2'b00);
        idle(3);

        // Out-of-range accesses, then sweep the whole in-range space.
        req(1'b1, 210, 16'hFFFF, 2'b11);
        req(1'b0, 210, 16'h0, 2'b00);
        req(1'b0, 255, 16'h0, 2'b00);
        for (int a = 0; a < DEPTH; a++) req(1'b0, a, 16'h0, 2'b00);
        idle(3);

        // Clear colliding with a read of address 5.
        clear = 1'b1;
        req(1'b0, 5, 16'h0, 2'b00);
        clear = 1'b0;
        idle(DEPTH);
        req(1'b0, 5, 16'h0, 2'b00);
        req(1'b0, 7, 16'h0, 2'b00);
        idle(3);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 1500; i++) begin
            req_valid = (($urandom % 4) != 0);
            req_we    = 1'($urandom % 2);
            req_addr  = AW'($urandom_range(0, 255));
            req_wdata = DW'($urandom);
            req_be    = 2'($urandom);
            clear     = (($urandom % 400) == 0);
            tick();
        end
        clear = 1'b0;
        idle(4);

        // Reset one cycle after a read is accepted: the response must vanish.
        req(1'b1, 3, 16'hBEEF, 2'b11);
        req(1'b0, 3, 16'h0, 2'b00);
        hold_reset(2);
        for (int i = 0; i < DEPTH; i++) begin
            req_valid = 1'b1;
            req_we    = 1'($urandom % 2);
            req_addr  = AW'($urandom_range(0, 255));
            req_wdata = DW'($urandom);
            req_be    = 2'b11;
            tick();
        end
        req(1'b0, 3, 16'h0, 2'b00);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_ram_bank.md
# sync_ram_bank

Parametrised synchronous single-port RAM bank: the next generation of our simple `awidth`/`dwidth` RAM model. It replaces the bidirectional data bus with separate write and read paths, adds byte enables, and adds a valid/ready request handshake with an in-order response pipeline of configurable latency. It zero-fills itself after reset or on command, and flags out-of-range accesses. It sits between a bus master or arbiter and on-chip storage, one instance per memory bank.

## Interface
- `AWIDTH`, 8: address width.
- `DWIDTH`, 16: data width; must be a multiple of 8.
- `DEPTH`, 2**AWIDTH: number of words, 1..2**AWIDTH.
- `RD_LAT`, 1: accept-to-response latency in cycles, 1..4.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bank can accept a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AWIDTH  word address.
- `req_wdata`  in  DWIDTH  write data.
- `req_be`  in  DWIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- `rsp_valid`  out  1  one-cycle pulse per accepted request.
- `rsp_rdata`  out  DWIDTH  read data; 0 for writes and errors.
- `rsp_err`  out  1  address >= DEPTH, qualified by `rsp_valid`.
- `clear`  in  1  single-cycle request to re-zero the whole bank.
- `init_busy`  out  1  zero-fill in progress.

## Operation
- FSM states: INIT, READY, CLEAR. Reset enters INIT.
- INIT and CLEAR behave identically:
  - A fill counter writes 0 to address 0..DEPTH-1, one word per cycle.
  - `init_busy` = 1 and `req_ready` = 0 throughout.
  - After writing address DEPTH-1, the FSM goes to READY.
- READY: `req_ready` = 1. A request is accepted when `req_valid && req_ready`.
- Accepted write:
  - Only bytes with `req_be` bit set are updated, at the accepting edge.
  - `req_be` = 0 is legal; it produces a response and writes nothing.
- Accepted read: returns the word as it stood before the accepting edge. A read accepted one cycle after a write to the same address sees the new data.
- Address >= DEPTH:
  - A write is discarded.
  - A read returns 0.
  - The response carries `rsp_err` = 1.
- Every accepted request yields exactly one response. Responses are in order, with no backpressure on the response side.
- `clear` in READY:
  - The FSM enters CLEAR on the next edge.
  - A request presented in the same cycle is accepted first.
  - `clear` in INIT or CLEAR is ignored.
- Responses already in flight at entry to CLEAR still complete, carrying their captured values.
- Reset asserted mid-operation:
  - In-flight responses are flushed and not delivered.
  - The FSM returns to INIT and contents are re-zeroed.
  - Memory itself has no reset term; it is zeroed only by the fill.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
  - `init_busy` = 1; FSM = INIT; fill counter = 0.
- Fill duration:
  - The first rising edge after `rst_n` deasserts writes address 0.
  - After DEPTH edges, `init_busy` = 0 and `req_ready` = 1.
- Response latency: a request accepted at edge N produces `rsp_valid` high during the cycle following edge N+RD_LAT-1. With RD_LAT = 1, the response is visible the cycle after acceptance.
- Throughput: one request per cycle in READY.
- Response outputs: `rsp_rdata` and `rsp_err` are 0 whenever `rsp_valid` = 0.
- CLEAR entry: a `clear` pulse at edge N drops `req_ready` for the cycle after N. CLEAR lasts DEPTH cycles.

## Structure
- Package `sync_ram_pkg` holds:
  - the FSM state enum (INIT, READY, CLEAR);
  - function `be_merge(old, new, be)` returning the byte-merged word;
  - constant `MAX_RD_LAT` = 4.
- Sub-module `sync_ram_rsp_pipe`, parametrised by DWIDTH and RD_LAT: a shift register of {valid, rdata, err} with an async reset of all valid bits.
- Elaboration-time checks: DWIDTH % 8 == 0; DEPTH <= 2**AWIDTH; 1 <= RD_LAT <= 4.

## Test plan
Configuration for all scenarios: AWIDTH = 8, DWIDTH = 16, DEPTH = 200, RD_LAT = 2.
- Fill after reset:
  - Release `rst_n`; `req_ready` stays 0 for 200 cycles, then goes to 1.
  - Reads of addresses 0, 99 and 199 each return 0x0000 with `rsp_err` = 0.
- Byte-enable write:
  - Write 0xABCD to address 5 with be = 2'b11, then write 0x1234 with be = 2'b01.
  - Read of address 5 returns 0xAB34, two cycles after acceptance.
- Back-to-back streaming:
  - Write address 7 = 0x5555, then read address 7 in the next cycle.
  - The read response is 0x5555.
  - Ten consecutive reads give ten consecutive `rsp_valid` pulses, in order.
- Out-of-range:
  - Write 0xFFFF to address 210, then read address 210.
  - Both responses have `rsp_err` = 1; the read data is 0x0000.
  - Addresses 0–199 are unchanged.
- Clear with collision:
  - Pulse `clear` in the same cycle as a read of address 5 (content 0xAB34).
  - The read is accepted and returns 0xAB34; `req_ready` is then low for 200 cycles.
  - Address 5 then reads 0x0000.
- Reset mid-flight:
  - Assert `rst_n` = 0 one cycle after a read is accepted.
  - No `rsp_valid` is delivered, all outputs take their reset values, and INIT restarts.
